// File: rtl/fht_result_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : fht_result_reader_if
// Description : Result stream bundle of fht_result_reader.
//               oDATA  - stream data word (D_BIT)
//               oVALID - stream valid
//               iREADY - stream ready (driven by the consumer)
//               oLAST  - high with the final point of an unload
//               master : the reader (source), slave : the consumer (sink)
// Revision    : 1.0 - initial release
// ============================================================================
interface fht_result_reader_if #(
  parameter int D_BIT = 22
);
  logic [D_BIT-1:0] oDATA;
  logic             oVALID;
  logic             iREADY;
  logic             oLAST;

  modport master (output oDATA, output oVALID, output oLAST, input iREADY);
  modport slave  (input oDATA, input oVALID, input oLAST, output iREADY);
endinterface
`default_nettype wire

// File: rtl/fht_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : fht_result_reader
// Description : Unloads the four fht_top result banks after a transform and
//               emits all 4*2^A_BIT points as one natural-order stream.
//               Output point n comes from bank n[1:0], row n>>2; each row is
//               fetched once and replayed beat by beat from a 4-word buffer.
// Macro       : FHT_RD_BIT_REV_EN - when defined, row address is the
//               bit-reversed row counter; when undefined the RAM is dumped in
//               natural row order (debug). Timing is identical either way.
// Ports       : iCLK, iRESET   - clock, synchronous active-high reset
//               iSTART         - one-cycle unload request
//               iRDY_FHT       - fht_top results stable (level)
//               oADDR_RD       - row address to all four fht_top read ports
//               iDATA_0..3     - bank 0..3 read data, RD_LAT after address
//               strm           - result stream (oDATA/oVALID/iREADY/oLAST)
//               oBUSY          - high outside IDLE
//               oDONE          - pulse after the final handshake
//               oABORT         - pulse when iRDY_FHT drops mid-unload
// Revision    : 1.0 - initial release
// ============================================================================
module fht_result_reader #(
  parameter int D_BIT  = 22,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 1    // 1..3
) (
  input  wire logic             iCLK,
  input  wire logic             iRESET,
  input  wire logic             iSTART,
  input  wire logic             iRDY_FHT,
  output logic [A_BIT-1:0]      oADDR_RD,
  input  wire logic [D_BIT-1:0] iDATA_0,
  input  wire logic [D_BIT-1:0] iDATA_1,
  input  wire logic [D_BIT-1:0] iDATA_2,
  input  wire logic [D_BIT-1:0] iDATA_3,
  fht_result_reader_if.master   strm,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic                  oABORT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  localparam logic [A_BIT-1:0] c_ROW_LAST = {A_BIT{1'b1}};
  // FETCH lasts RD_LAT+1 cycles: address cycle plus RD_LAT read latency.
  localparam logic [1:0]       c_WAIT_END = 2'(RD_LAT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [A_BIT-1:0] r_row;
  logic [A_BIT-1:0] w_row_inc;
  logic [1:0]       r_beat;
  logic [1:0]       r_wait;
  logic [D_BIT-1:0] r_buf [0:3];
  logic             r_done;
  logic             r_abort;
  logic             w_hs;
  logic             w_row_last;

  function automatic logic [A_BIT-1:0] f_row_addr(input logic [A_BIT-1:0] row);
    logic [A_BIT-1:0] v;
`ifdef FHT_RD_BIT_REV_EN
    for (int i = 0; i < A_BIT; i++) begin
      v[i] = row[A_BIT-1-i];
    end
`else
    v = row;
`endif
    return v;
  endfunction

  assign w_row_inc  = r_row + 1'b1;
  assign w_row_last = (r_row == c_ROW_LAST);
  assign w_hs       = (r_state == ST_SEND) && strm.iREADY;

  // Next state; a drop of iRDY_FHT overrides any handshake in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iSTART && iRDY_FHT) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!iRDY_FHT)                 w_state_nxt = ST_IDLE;
        else if (r_wait == c_WAIT_END) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (!iRDY_FHT)                  w_state_nxt = ST_IDLE;
        else if (w_hs && r_beat == 2'd3) w_state_nxt = w_row_last ? ST_IDLE : ST_FETCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state  <= ST_IDLE;
      r_row    <= '0;
      r_beat   <= '0;
      r_wait   <= '0;
      oADDR_RD <= '0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iSTART && iRDY_FHT) begin
            r_row    <= '0;
            r_beat   <= '0;
            r_wait   <= '0;
            oADDR_RD <= f_row_addr('0);
          end
        end
        ST_FETCH: begin
          if (!iRDY_FHT) begin
            r_row   <= '0;
            r_abort <= 1'b1;
          end else begin
            r_wait <= r_wait + 2'd1;
            if (r_wait == c_WAIT_END) begin
              r_buf[0] <= iDATA_0;
              r_buf[1] <= iDATA_1;
              r_buf[2] <= iDATA_2;
              r_buf[3] <= iDATA_3;
              r_beat   <= '0;
            end
          end
        end
        ST_SEND: begin
          if (!iRDY_FHT) begin
            r_row   <= '0;
            r_abort <= 1'b1;
          end else if (w_hs) begin
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd3) begin
              if (w_row_last) begin
                r_row  <= '0;
                r_done <= 1'b1;
              end else begin
                r_row    <= w_row_inc;
                r_wait   <= '0;
                oADDR_RD <= f_row_addr(w_row_inc);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign strm.oVALID = (r_state == ST_SEND);
  assign strm.oDATA  = strm.oVALID ? r_buf[r_beat] : '0;
  assign strm.oLAST  = strm.oVALID && (r_beat == 2'd3) && w_row_last;
  assign oBUSY       = (r_state != ST_IDLE);
  assign oDONE       = r_done;
  assign oABORT      = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_fht_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fht_result_reader
// Description : Scoreboard bench for fht_result_reader with A_BIT=3,
//               RD_LAT=1. Bank b row r holds 16*r+b; expected stream order
//               follows FHT_RD_BIT_REV_EN (bit-reversed or natural rows).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fht_result_reader;
  localparam int D_BIT  = 22;
  localparam int A_BIT  = 3;
  localparam int RD_LAT = 1;
  localparam int NPTS   = 4 * (1 << A_BIT);

`ifdef FHT_RD_BIT_REV_EN
  localparam int ROW_ORDER [0:7] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  localparam int ROW_ORDER [0:7] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  typedef struct packed {
    logic [D_BIT-1:0] d;
    logic             l;
  } exp_t;

  logic             clk = 1'b0;
  logic             iRESET, iSTART, iRDY_FHT;
  logic [A_BIT-1:0] addr;
  logic [D_BIT-1:0] d0, d1, d2, d3;
  logic             busy, done, abort_p;

  fht_result_reader_if #(.D_BIT(D_BIT)) strm_if ();

  fht_result_reader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT)) dut (
    .iCLK(clk), .iRESET(iRESET), .iSTART(iSTART), .iRDY_FHT(iRDY_FHT),
    .oADDR_RD(addr), .iDATA_0(d0), .iDATA_1(d1), .iDATA_2(d2), .iDATA_3(d3),
    .strm(strm_if.master), .oBUSY(busy), .oDONE(done), .oABORT(abort_p)
  );

  always #5 clk = ~clk;

  // fht_top read model: RD_LAT-stage address pipeline in front of the RAM.
  logic [A_BIT-1:0] addr_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    addr_pipe[0] <= addr;
    for (int k = 1; k < RD_LAT; k++) addr_pipe[k] <= addr_pipe[k-1];
  end

  function automatic logic [D_BIT-1:0] ram_word(input int b, input logic [A_BIT-1:0] r);
    return D_BIT'(16 * int'(r) + b);
  endfunction

  assign d0 = ram_word(0, addr_pipe[RD_LAT-1]);
  assign d1 = ram_word(1, addr_pipe[RD_LAT-1]);
  assign d2 = ram_word(2, addr_pipe[RD_LAT-1]);
  assign d3 = ram_word(3, addr_pipe[RD_LAT-1]);

  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   hs_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int   first_hs_cyc = 0, last_cyc = 0, done_cyc = 0;
  exp_t exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold stability.
  logic             held_v = 1'b0;
  logic [D_BIT-1:0] held_d = '0;
  logic             held_l = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (held_v && strm_if.oVALID) begin
      check("hold_data", int'(strm_if.oDATA), int'(held_d));
      check("hold_last", int'(strm_if.oLAST), int'(held_l));
    end
    if (strm_if.oVALID && strm_if.iREADY) begin
      hs_cnt++;
      if (hs_cnt == 1) first_hs_cyc = cyc;
      if (strm_if.oLAST) last_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got data 0x%0h, expected no beat", strm_if.oDATA);
      end else begin
        e = exp_q.pop_front();
        check("stream_data", int'(strm_if.oDATA), int'(e.d));
        check("stream_last", int'(strm_if.oLAST), int'(e.l));
      end
    end
    held_v = strm_if.oVALID && !strm_if.iREADY;
    held_d = strm_if.oDATA;
    held_l = strm_if.oLAST;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (abort_p) abort_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all();
    exp_t e;
    for (int n = 0; n < NPTS; n++) begin
      e.d = D_BIT'(16 * ROW_ORDER[n / 4] + (n % 4));
      e.l = (n == NPTS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_hs(input int n);
    int b = 0;
    while (hs_cnt < n && b < 500) begin tick(); b++; end
    if (hs_cnt < n) begin
      checks++; errors++;
      $display("FAIL wait_hs: got %0d handshakes, expected %0d", hs_cnt, n);
    end
  endtask

  task automatic wait_done(input int d0_cnt);
    int b = 0;
    while (done_cnt == d0_cnt && b < 500) begin tick(); b++; end
    if (done_cnt == d0_cnt) begin
      checks++; errors++;
      $display("FAIL wait_done: no oDONE within budget, hs=%0d", hs_cnt);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"},  int'(addr), 0);
    check({tag, "_data"},  int'(strm_if.oDATA), 0);
    check({tag, "_valid"}, int'(strm_if.oVALID), 0);
    check({tag, "_last"},  int'(strm_if.oLAST), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_abort"}, int'(abort_p), 0);
  endtask

  task automatic start_unload();
    hs_cnt = 0;
    exp_q.delete();
    push_all();
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
  endtask

  initial begin
    int t, dc, ac, k;
    iRESET = 1'b1; iSTART = 1'b0; iRDY_FHT = 1'b0; strm_if.iREADY = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    iRESET = 1'b0;
    tick();

    // Full unload with iREADY held high: ordering and latency.
    iRDY_FHT = 1'b1; strm_if.iREADY = 1'b1;
    dc = done_cnt;
    t = cyc;
    start_unload();
    wait_done(dc);
    check("full_first_valid_cyc", first_hs_cyc, t + 2 + RD_LAT);
    check("full_last_cyc", last_cyc, t + 48);
    check("full_done_cyc", done_cyc, t + 49);
    check("full_count", hs_cnt, NPTS);
    check("full_queue_left", exp_q.size(), 0);
    check("full_busy_after", int'(busy), 0);
    check("full_no_abort", abort_cnt, 0);

    // Start gating: iSTART without iRDY_FHT is ignored.
    iRDY_FHT = 1'b0;
    iSTART = 1'b1; tick(); iSTART = 1'b0; tick();
    check("gate_busy", int'(busy), 0);
    repeat (4) tick();
    check("gate_valid", int'(strm_if.oVALID), 0);
    check("gate_abort", abort_cnt, 0);

    // Backpressure 1,0,0,1 with stray iSTART pulses during the unload.
    iRDY_FHT = 1'b1;
    tick();
    dc = done_cnt;
    start_unload();
    k = 0;
    while (done_cnt == dc && k < 600) begin
      strm_if.iREADY = (k % 4 == 0) || (k % 4 == 3);
      iSTART = (k % 5 == 2) && (hs_cnt < NPTS - 4);
      tick();
      k++;
    end
    iSTART = 1'b0; strm_if.iREADY = 1'b1;
    check("bp_done_seen", int'(done_cnt != dc), 1);
    check("bp_count", hs_cnt, NPTS);
    check("bp_queue_left", exp_q.size(), 0);
    tick();
    check("bp_busy_after", int'(busy), 0);

    // Abort: drop iRDY_FHT after 10 handshakes.
    dc = done_cnt; ac = abort_cnt;
    start_unload();
    wait_hs(10);
    iRDY_FHT = 1'b0; strm_if.iREADY = 1'b0;
    tick();
    check("abort_valid", int'(strm_if.oVALID), 0);
    check("abort_pulse", int'(abort_p), 1);
    check("abort_busy", int'(busy), 0);
    tick();
    check("abort_pulse_width", int'(abort_p), 0);
    repeat (3) tick();
    check("abort_no_done", done_cnt, dc);
    check("abort_count", abort_cnt, ac + 1);
    check("abort_hs_stopped", hs_cnt, 10);
    iRDY_FHT = 1'b1; strm_if.iREADY = 1'b1;
    tick();
    start_unload();
    wait_done(dc);
    check("restart_count", hs_cnt, NPTS);
    check("restart_queue_left", exp_q.size(), 0);

    // Reset at beat 5.
    tick();
    dc = done_cnt; ac = abort_cnt;
    start_unload();
    wait_hs(5);
    iRESET = 1'b1; strm_if.iREADY = 1'b0;
    tick();
    iRESET = 1'b0;
    check_idle_outputs("midreset");
    repeat (4) tick();
    check("midreset_no_done", done_cnt, dc);
    check("midreset_no_abort", abort_cnt, ac);
    strm_if.iREADY = 1'b1;
    start_unload();
    wait_done(dc);
    check("post_reset_count", hs_cnt, NPTS);
    check("post_reset_queue_left", exp_q.size(), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
